braid_inject_sequencer: RTL and testbench

//  Drives the fluid inputs of a braid mixer array (e.g. 8-input, 16-stage braid).

---
 rtl/braid_inject_sequencer.sv | 134 +++++++++++++
 tb/tb_braid_inject_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/braid_inject_sequencer.sv
// Injection sequencer for a braid mixer: buffers (channel, volume) requests, opens one input
// valve at a time for the requested cycles, then holds a closed settle gap before reporting done.
module braid_inject_sequencer #(
    parameter int unsigned N_INPUTS   = 8,
    parameter int unsigned CH_W       = 3,
    parameter int unsigned VOL_W      = 8,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CH_W-1:0]     req_chan,
    input  logic [VOL_W-1:0]    req_vol,
    output logic [N_INPUTS-1:0] valve_en,
    output logic                pump_en,
    output logic                busy,
    output logic                done,
    output logic                err_chan
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SET_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StOpen, StSettle} state_e;

    logic [CH_W-1:0]  fifo_chan [FIFO_DEPTH];
    logic [VOL_W-1:0] fifo_vol  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    state_e           state_q, state_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [VOL_W-1:0] remaining_q, remaining_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             err_q, err_d;

    logic             push, pop, chan_ok;
    logic [CH_W-1:0]  head_chan;
    logic [VOL_W-1:0] head_vol;

    // Ready is purely occupancy based, so a full FIFO never accepts even when popping.
    assign req_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign head_chan = fifo_chan[rd_ptr_q];
    assign head_vol  = fifo_vol[rd_ptr_q];
    assign chan_ok   = (32'(head_chan) < N_INPUTS);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_chan[wr_ptr_q] <= req_chan;
            fifo_vol[wr_ptr_q]  <= req_vol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            chan_q      <= '0;
            remaining_q <= '0;
            settle_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            remaining_q <= remaining_d;
            settle_q    <= settle_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        remaining_d = remaining_q;
        settle_d    = settle_q;
        err_d       = err_q;
        valve_en    = '0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    chan_d = head_chan;
                    if (head_vol != '0 && chan_ok) begin
                        state_d     = StOpen;
                        remaining_d = head_vol;
                    end else begin
                        // Zero-volume or bad-channel requests still get a settle window and done.
                        state_d  = StSettle;
                        settle_d = SET_W'(SETTLE);
                        if (!chan_ok) err_d = 1'b1;
                    end
                end
            end
            StOpen: begin
                valve_en    = N_INPUTS'(1) << chan_q;
                remaining_d = remaining_q - VOL_W'(1);
                if (remaining_q == VOL_W'(1)) begin
                    state_d  = StSettle;
                    settle_d = SET_W'(SETTLE);
                end
            end
            StSettle: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pump_en  = |valve_en;
    assign busy     = (state_q != StIdle) || (count_q != '0);
    assign err_chan = err_q;

endmodule

// File: tb/tb_braid_inject_sequencer.sv
// Scoreboard bench for braid_inject_sequencer: directed requests with hand-computed open/settle
// lengths, plus a second instance narrowed to six inputs for the bad-channel path.
module tb_braid_inject_sequencer;
    localparam int SETTLE = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_chan = '0;
    logic [7:0] req_vol = '0;
    logic [7:0] valve_en;
    logic       pump_en, busy, done, err_chan;

    logic       v6 = 1'b0;
    logic       rdy6;
    logic [2:0] ch6 = '0;
    logic [7:0] vol6 = '0;
    logic [5:0] valve6;
    logic       pump6, busy6, done6, err6;

    braid_inject_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_chan(req_chan), .req_vol(req_vol), .valve_en(valve_en), .pump_en(pump_en),
        .busy(busy), .done(done), .err_chan(err_chan)
    );

    braid_inject_sequencer #(.N_INPUTS(6), .CH_W(3)) dut6 (
        .clk(clk), .rst(rst), .req_valid(v6), .req_ready(rdy6),
        .req_chan(ch6), .req_vol(vol6), .valve_en(valve6), .pump_en(pump6),
        .busy(busy6), .done(done6), .err_chan(err6)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct { int chan; int vol; } exp_t;
    exp_t exp_q[$];

    // Monitor: invariants every cycle, and a per-request comparison on each done pulse.
    exp_t       e_cur;
    logic [7:0] run_mask, exp_mask;
    int         open_len = 0, closed_since = 0;
    bit         seen_open = 0;

    always @(negedge clk) begin
        if (rst) begin
            run_mask = '0; open_len = 0; closed_since = 0; seen_open = 0;
        end else begin
            check("onehot", 64'($countones(valve_en) <= 1), 1);
            check("pump_en", pump_en, |valve_en);
            if (valve_en != '0) begin
                if (open_len == 0) begin
                    if (seen_open) check("closed_gap", 64'(closed_since >= SETTLE), 1);
                    run_mask = valve_en;
                end else begin
                    check("run_channel", valve_en, run_mask);
                end
                open_len++;
                closed_since = 0;
                seen_open = 1;
            end else begin
                closed_since++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("open_cycles", open_len, e_cur.vol);
                    if (e_cur.vol > 0) begin
                        exp_mask = 8'd1 << e_cur.chan;
                        check("open_chan", run_mask, exp_mask);
                        check("settle_len", closed_since, SETTLE);
                    end
                end
                open_len = 0;
                run_mask = '0;
            end
        end
    end

    task automatic push8(input int ch, input int vol);
        int n = 0;
        req_chan  = 3'(ch);
        req_vol   = 8'(vol);
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            check("push_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back('{ch, vol});
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Cycles counted from the accepting edge of the last push.
    task automatic time_req(output int first_open, output int done_at, output logic [7:0] open_val);
        first_open = -1;
        done_at    = -1;
        open_val   = '0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            if (valve_en != '0 && first_open < 0) begin
                first_open = k;
                open_val   = valve_en;
            end
            if (done) begin
                done_at = k;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    int         fo, da, ndone, seen6;
    logic [7:0] ov;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valve", valve_en, 0);
        check("rst_pump", pump_en, 0);
        check("rst_done", done, 0);
        check("rst_err", err_chan, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        check("rst_ready6", rdy6, 1);

        // single request timing
        push8(2, 3);
        time_req(fo, da, ov);
        check("t1_first_open", 64'(fo), 1);
        check("t1_open_val", ov, 8'h04);
        check("t1_done_at", 64'(da), 3 + SETTLE);
        @(posedge clk); #1;
        check("t1_busy_falls", busy, 0);

        // five back-to-back, FIFO fills
        push8(6, 6);
        push8(1, 2);
        push8(3, 1);
        push8(4, 0);
        push8(7, 4);
        check("t2_ready_full", req_ready, 0);
        wait_idle8();

        // zero volume
        push8(7, 0);
        time_req(fo, da, ov);
        check("t3_no_open", 64'(fo), 64'(-1));
        check("t3_done_at", 64'(da), SETTLE);
        check("t3_err", err_chan, 0);
        wait_idle8();

        // maximum volume
        push8(1, 255);
        time_req(fo, da, ov);
        check("t6_done_at", 64'(da), 255 + SETTLE);
        wait_idle8();

        for (int i = 0; i < 8; i++) push8(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
        wait_idle8();

        // reset during the 2nd open cycle with a request still queued
        push8(0, 10);
        push8(3, 4);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_valve", valve_en, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", req_ready, 1);
        check("t5_done", done, 0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("t5_no_done", 64'(ndone), 0);

        // six-input instance: out-of-range channel
        ch6 = 3'd6; vol6 = 8'd5; v6 = 1'b1;
        @(posedge clk); #1;
        v6 = 1'b0;
        seen6 = 0; da = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (valve6 != '0) seen6 = 1;
            if (done6) begin
                da = k;
                break;
            end
        end
        check("t4_no_valve", 64'(seen6), 0);
        check("t4_done_at", 64'(da), SETTLE);
        check("t4_err", err6, 1);
        ch6 = 3'd5; vol6 = 8'd2; v6 = 1'b1;
        @(posedge clk); #1;
        v6 = 1'b0;
        seen6 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (valve6 == 6'h20) seen6++;
            if (done6) break;
        end
        check("t4_valid_open", 64'(seen6), 2);
        check("t4_err_sticky", err6, 1);

        check("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
